// File: rtl/oam_dma.sv
// oam_dma: sprite DMA, copies CPU page $XX00-$XXFF into the OAM data register.
// Latency: state/outputs advance one step per CPU cycle (clk edge with ph2_falling=1); 513 halted cycles.
// Backpressure: none; the CPU is held off via cpu_halt. Macro OAM_DMA_ODD_ALIGN_EN adds an even-cycle alignment step.
module oam_dma #(
  parameter logic [15:0] OAM_DATA_ADDR = 16'h2004,
  parameter int unsigned DMA_LEN       = 256
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        ph1_rising,
  input  logic        ph1_falling,
  input  logic        ph2_rising,
  input  logic        ph2_falling,
  input  logic        trig_cs,
  input  logic        trig_rnw,
  input  logic [7:0]  trig_din,
  output logic        cpu_halt,
  output logic        dma_active,
  output logic [15:0] dma_addr,
  output logic        dma_rnw,
  output logic [7:0]  dma_dout,
  input  logic [7:0]  dma_din
);

  // Count value of the final byte; the counter is 8 bits, so a full page is 0..FF.
  localparam logic [7:0] LAST_CNT = 8'(DMA_LEN - 1);

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_HALT  = 3'd1,
`ifdef OAM_DMA_ODD_ALIGN_EN
    ST_ALIGN = 3'd2,
`endif
    ST_READ  = 3'd3,
    ST_WRITE = 3'd4
  } state_t;

  state_t      state_q, state_d;
  logic [7:0]  page_q, page_d;
  logic [7:0]  cnt_q, cnt_d;
  logic [7:0]  data_q, data_d;
  logic        parity_q, parity_d;
  logic        cpu_halt_q, cpu_halt_d;
  logic        dma_active_q, dma_active_d;
  logic [15:0] dma_addr_q, dma_addr_d;
  logic        dma_rnw_q, dma_rnw_d;
  logic [7:0]  dma_dout_q, dma_dout_d;

  // Phase strobes other than ph2_falling are kept only as a debug hook.
  logic unused_phase;
  assign unused_phase = ph1_rising ^ ph1_falling ^ ph2_rising;

  // State register plus all datapath and output flops; reset aborts any transfer.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= ST_IDLE;
      page_q       <= 8'h00;
      cnt_q        <= 8'h00;
      data_q       <= 8'h00;
      parity_q     <= 1'b0;
      cpu_halt_q   <= 1'b0;
      dma_active_q <= 1'b0;
      dma_addr_q   <= 16'h0000;
      dma_rnw_q    <= 1'b1;
      dma_dout_q   <= 8'h00;
    end else begin
      state_q      <= state_d;
      page_q       <= page_d;
      cnt_q        <= cnt_d;
      data_q       <= data_d;
      parity_q     <= parity_d;
      cpu_halt_q   <= cpu_halt_d;
      dma_active_q <= dma_active_d;
      dma_addr_q   <= dma_addr_d;
      dma_rnw_q    <= dma_rnw_d;
      dma_dout_q   <= dma_dout_d;
    end
  end

  // Next-state and datapath updates, evaluated only at a CPU cycle boundary.
  always_comb begin
    state_d  = state_q;
    page_d   = page_q;
    cnt_d    = cnt_q;
    data_d   = data_q;
    parity_d = parity_q;
    if (ph2_falling) begin
      parity_d = ~parity_q;
      case (state_q)
        ST_IDLE: begin
          // Only a CPU write to $4014 starts a transfer; triggers elsewhere are ignored.
          if (trig_cs && !trig_rnw) begin
            state_d = ST_HALT;
            page_d  = trig_din;
            cnt_d   = 8'h00;
          end
        end
        ST_HALT: begin
`ifdef OAM_DMA_ODD_ALIGN_EN
          // Leaving HALT on an odd cycle costs one extra cycle so reads land on even cycles.
          state_d = parity_q ? ST_ALIGN : ST_READ;
`else
          state_d = ST_READ;
`endif
        end
`ifdef OAM_DMA_ODD_ALIGN_EN
        ST_ALIGN: state_d = ST_READ;
`endif
        ST_READ: begin
          data_d  = dma_din;
          state_d = ST_WRITE;
        end
        ST_WRITE: begin
          // The counter wraps to 0 only when the last byte is done; page stays fixed.
          cnt_d = cnt_q + 8'd1;
          if (cnt_q == LAST_CNT) begin
            state_d = ST_IDLE;
          end else begin
            state_d = ST_READ;
          end
        end
        default: state_d = ST_IDLE;
      endcase
    end
  end

  // Registered outputs for the CPU cycle being entered, derived from the next state.
  always_comb begin
    cpu_halt_d   = cpu_halt_q;
    dma_active_d = dma_active_q;
    dma_addr_d   = dma_addr_q;
    dma_rnw_d    = dma_rnw_q;
    dma_dout_d   = dma_dout_q;
    if (ph2_falling) begin
      case (state_d)
        ST_IDLE: begin
          cpu_halt_d   = 1'b0;
          dma_active_d = 1'b0;
          dma_addr_d   = 16'h0000;
          dma_rnw_d    = 1'b1;
          dma_dout_d   = 8'h00;
        end
        ST_READ: begin
          cpu_halt_d   = 1'b1;
          dma_active_d = 1'b1;
          dma_addr_d   = {page_d, cnt_d};
          dma_rnw_d    = 1'b1;
        end
        ST_WRITE: begin
          cpu_halt_d   = 1'b1;
          dma_active_d = 1'b1;
          dma_addr_d   = OAM_DATA_ADDR;
          dma_rnw_d    = 1'b0;
          dma_dout_d   = data_d;
        end
        default: begin
          // Dead cycles (HALT/ALIGN): bus idle, address and data held.
          cpu_halt_d   = 1'b1;
          dma_active_d = 1'b1;
          dma_rnw_d    = 1'b1;
        end
      endcase
    end
  end

  assign cpu_halt   = cpu_halt_q;
  assign dma_active = dma_active_q;
  assign dma_addr   = dma_addr_q;
  assign dma_rnw    = dma_rnw_q;
  assign dma_dout   = dma_dout_q;

endmodule

// File: tb/tb_oam_dma.sv
// tb_oam_dma: random CPU-cycle lengths and source pages; expected bus cycles queued per trigger,
// a monitor compares every CPU cycle of the bus against the queue (idle when the queue is empty).
`timescale 1ns/1ps
module tb_oam_dma;

  logic        clk = 1'b0;
  logic        rst;
  logic        ph1_rising, ph1_falling, ph2_rising, ph2_falling;
  logic        trig_cs, trig_rnw;
  logic [7:0]  trig_din;
  logic        cpu_halt, dma_active, dma_rnw;
  logic [15:0] dma_addr;
  logic [7:0]  dma_dout, dma_din;
  logic [7:0]  key;

  int checks = 0;
  int errors = 0;
  int strobe_cnt = 0;
  int hcnt = 0;

  typedef struct packed {
    logic        halt;
    logic        rnw;
    logic [15:0] addr;
    logic        chk_dout;
    logic [7:0]  dout;
  } exp_t;

  exp_t exp_q[$];
  int   len_q[$];

  oam_dma dut (
    .clk(clk), .rst(rst),
    .ph1_rising(ph1_rising), .ph1_falling(ph1_falling),
    .ph2_rising(ph2_rising), .ph2_falling(ph2_falling),
    .trig_cs(trig_cs), .trig_rnw(trig_rnw), .trig_din(trig_din),
    .cpu_halt(cpu_halt), .dma_active(dma_active), .dma_addr(dma_addr),
    .dma_rnw(dma_rnw), .dma_dout(dma_dout), .dma_din(dma_din)
  );

  always #20 clk = ~clk;

  // Memory model: byte at any address is its low byte XOR a per-transfer key.
  assign dma_din = dma_addr[7:0] ^ key;

  function automatic logic [7:0] mem_byte(input logic [7:0] page, input logic [7:0] off);
    mem_byte = off ^ key;
    if (page == 8'hxx) mem_byte = 8'hxx;
  endfunction

  function automatic exp_t mk(input logic h, input logic r, input logic [15:0] a,
                              input logic c, input logic [7:0] d);
    exp_t e;
    e.halt = h; e.rnw = r; e.addr = a; e.chk_dout = c; e.dout = d;
    return e;
  endfunction

  // CPU phase generator with a random 3..6 clk cycle length.
  initial begin
    int len;
    ph1_rising = 0; ph1_falling = 0; ph2_rising = 0; ph2_falling = 0;
    forever begin
      len = $urandom_range(3, 6);
      for (int i = 0; i < len; i++) begin
        @(posedge clk); #1;
        ph1_rising  = (i == 0);
        ph1_falling = (i == 1);
        ph2_rising  = (i == len - 2);
        ph2_falling = (i == len - 1);
      end
    end
  end

  // Number of CPU cycle boundaries since reset release.
  always @(posedge clk) begin
    if (rst) strobe_cnt = 0;
    else if (ph2_falling) strobe_cnt = strobe_cnt + 1;
  end

  // Monitor: one comparison per CPU cycle, plus halted-length check at each transfer end.
  initial begin : monitor
    exp_t e;
    forever begin
      @(negedge clk);
      if (rst) begin
        hcnt = 0;
        continue;
      end
      if (ph2_falling !== 1'b1) continue;
      if (exp_q.size() > 0) e = exp_q.pop_front();
      else e = mk(1'b0, 1'b1, 16'h0000, 1'b1, 8'h00);
      checks++;
      if (cpu_halt !== e.halt || dma_active !== e.halt || dma_rnw !== e.rnw ||
          dma_addr !== e.addr || (e.chk_dout && dma_dout !== e.dout)) begin
        errors++;
        $display("FAIL bus_cycle t=%0t got halt=%b act=%b rnw=%b addr=%h dout=%h want halt=%b rnw=%b addr=%h dout=%h(chk=%b)",
                 $time, cpu_halt, dma_active, dma_rnw, dma_addr, dma_dout,
                 e.halt, e.rnw, e.addr, e.dout, e.chk_dout);
      end
      if (cpu_halt === 1'b1) begin
        hcnt++;
      end else if (hcnt != 0) begin
        checks++;
        if (len_q.size() == 0) begin
          errors++;
          $display("FAIL halt_len got %0d cycles, no transfer expected", hcnt);
        end else begin
          int want;
          want = len_q.pop_front();
          if (hcnt != want) begin
            errors++;
            $display("FAIL halt_len got %0d cycles want %0d", hcnt, want);
          end
        end
        hcnt = 0;
      end
    end
  end

  // Returns just after a clk edge that ended a CPU cycle.
  task automatic wait_strobe();
    do @(posedge clk); while (ph2_falling !== 1'b1);
    #2;
  endtask

  // Issue a $4014 write so that the HALT cycle ends with the requested parity
  // (halt_par = -1: no preference), and queue the full expected bus sequence.
  task automatic start_transfer(input logic [7:0] page, input int halt_par);
    int k;
    bit align;
    wait_strobe();
    if (halt_par >= 0 && ((strobe_cnt + 1) % 2) != halt_par) wait_strobe();
    k = strobe_cnt;
    trig_cs = 1'b1; trig_rnw = 1'b0; trig_din = page;
    wait_strobe();
    trig_cs = 1'b0; trig_din = 8'($urandom);
`ifdef OAM_DMA_ODD_ALIGN_EN
    align = ((k + 1) % 2) == 1;
`else
    align = 1'b0;
`endif
    exp_q.push_back(mk(1'b1, 1'b1, 16'h0000, 1'b0, 8'h00));
    if (align) exp_q.push_back(mk(1'b1, 1'b1, 16'h0000, 1'b0, 8'h00));
    for (int i = 0; i < 256; i++) begin
      exp_q.push_back(mk(1'b1, 1'b1, {page, 8'(i)}, 1'b0, 8'h00));
      exp_q.push_back(mk(1'b1, 1'b0, 16'h2004, 1'b1, mem_byte(page, 8'(i))));
    end
    len_q.push_back(align ? 514 : 513);
  endtask

  task automatic wait_done();
    int n = 0;
    while (exp_q.size() != 0 && n < 5000) begin
      @(posedge clk);
      n++;
    end
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL transfer_timeout got %0d cycles pending want 0", exp_q.size());
    end
    repeat (3) wait_strobe();
  endtask

  initial begin : stimulus
    logic [7:0] pg;
    int n;
    rst = 1'b1; trig_cs = 1'b0; trig_rnw = 1'b1; trig_din = 8'h00; key = 8'h5A;
    #5;
    checks++;
    if (cpu_halt !== 1'b0 || dma_active !== 1'b0 || dma_rnw !== 1'b1 ||
        dma_addr !== 16'h0000 || dma_dout !== 8'h00) begin
      errors++;
      $display("FAIL reset_state got halt=%b act=%b rnw=%b addr=%h dout=%h", cpu_halt, dma_active, dma_rnw, dma_addr, dma_dout);
    end
    repeat (3) @(posedge clk);
    #2 rst = 1'b0;

    // Page 2, no alignment; a second $4014 write mid-transfer must be ignored.
    start_transfer(8'h02, 0);
    repeat (100) wait_strobe();
    trig_cs = 1'b1; trig_rnw = 1'b0; trig_din = 8'h07;
    wait_strobe();
    trig_cs = 1'b0;
    wait_done();

    // CPU read of $4014 must not start anything.
    trig_cs = 1'b1; trig_rnw = 1'b1; trig_din = 8'h03;
    wait_strobe();
    trig_cs = 1'b0;
    repeat (4) wait_strobe();
    checks++;
    if (cpu_halt !== 1'b0) begin
      errors++;
      $display("FAIL read_no_trigger got cpu_halt=%b want 0", cpu_halt);
    end

    // HALT ends on an odd cycle.
    key = 8'($urandom);
    start_transfer(8'($urandom), 1);
    wait_done();

    // Reset during READ at cnt=40.
    key = 8'($urandom);
    pg = 8'($urandom);
    start_transfer(pg, -1);
    n = 0;
    while (!(cpu_halt === 1'b1 && dma_rnw === 1'b1 && dma_addr === {pg, 8'h40}) && n < 5000) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (n >= 5000) begin
      errors++;
      $display("FAIL abort_reach got addr=%h want %h", dma_addr, {pg, 8'h40});
    end
    #1 rst = 1'b1;
    #1;
    checks++;
    if (cpu_halt !== 1'b0 || dma_active !== 1'b0 || dma_rnw !== 1'b1 ||
        dma_addr !== 16'h0000 || dma_dout !== 8'h00) begin
      errors++;
      $display("FAIL abort_reset got halt=%b act=%b rnw=%b addr=%h dout=%h want 0 0 1 0000 00",
               cpu_halt, dma_active, dma_rnw, dma_addr, dma_dout);
    end
    exp_q.delete();
    len_q.delete();
    repeat (3) @(posedge clk);
    #2 rst = 1'b0;
    repeat (2) wait_strobe();

    // Full transfers after the abort, random pages and alignment.
    for (int t = 0; t < 3; t++) begin
      key = 8'($urandom);
      start_transfer(8'($urandom), -1);
      wait_done();
    end

    repeat (5) wait_strobe();
    checks++;
    if (exp_q.size() != 0 || len_q.size() != 0) begin
      errors++;
      $display("FAIL queues_drained got %0d/%0d want 0/0", exp_q.size(), len_q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  // Watchdog.
  initial begin
    repeat (60000) @(posedge clk);
    $display("FAIL watchdog got timeout want completion");
    $fatal(1, "watchdog");
  end

endmodule
